alu_issue_ctrl: RTL

//  Shares one 8-bit ALU (IN1/IN2/OPCODE -> result/overflow) between two requesters,
//  e.g. the branch-compare unit and the execute stage.

---
 rtl/alu_issue_ctrl.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/alu_issue_ctrl.sv
// Shares one ALU between two requesters: round-robin grant, registered ALU operands,
// fixed-latency result capture and a held response channel tagged with the requester id.
module alu_issue_ctrl #(
    parameter int unsigned ALU_LAT = 1,
    parameter logic [5:0]  IDLE_OP = 6'b110101
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  req_valid,
    output logic [1:0]  req_ready,
    input  logic [15:0] req_in1,
    input  logic [15:0] req_in2,
    input  logic [11:0] req_opcode,
    output logic [7:0]  alu_in1,
    output logic [7:0]  alu_in2,
    output logic [5:0]  alu_opcode,
    input  logic [7:0]  alu_result,
    input  logic        alu_overflow,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic        rsp_id,
    output logic [7:0]  rsp_result,
    output logic        rsp_overflow,
    output logic        busy
);

    localparam int unsigned DATA_W = 8;
    localparam int unsigned OP_W   = 6;
    localparam int unsigned CNT_W  = 3;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_e;

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                last_grant_q, last_grant_d;
    logic                rid_q, rid_d;
    logic [DATA_W-1:0]   alu_in1_q, alu_in1_d;
    logic [DATA_W-1:0]   alu_in2_q, alu_in2_d;
    logic [OP_W-1:0]     alu_op_q, alu_op_d;
    logic                rsp_valid_q, rsp_valid_d;
    logic                rsp_id_q, rsp_id_d;
    logic [DATA_W-1:0]   rsp_result_q, rsp_result_d;
    logic                rsp_ovf_q, rsp_ovf_d;

    logic                gnt_any_c;
    logic                gnt_id_c;
    logic                accept_c;
    logic                wait_done_c;

    // Round-robin pick: a lone requester wins, on contention the one not served last.
    always_comb begin
        gnt_any_c   = |req_valid;
        gnt_id_c    = (req_valid == 2'b11) ? ~last_grant_q : req_valid[1];
        accept_c    = (state_q == S_IDLE) && gnt_any_c && !reset;
        wait_done_c = (cnt_q == CNT_W'(1));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (accept_c)    state_d = S_WAIT;
            S_WAIT:  if (wait_done_c) state_d = S_RESP;
            S_RESP:  if (rsp_ready)   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        req_ready    = 2'b00;
        cnt_d        = cnt_q;
        last_grant_d = last_grant_q;
        rid_d        = rid_q;
        alu_in1_d    = alu_in1_q;
        alu_in2_d    = alu_in2_q;
        alu_op_d     = alu_op_q;
        rsp_valid_d  = rsp_valid_q;
        rsp_id_d     = rsp_id_q;
        rsp_result_d = rsp_result_q;
        rsp_ovf_d    = rsp_ovf_q;
        case (state_q)
            S_IDLE: begin
                if (accept_c) begin
                    req_ready    = gnt_id_c ? 2'b10 : 2'b01;
                    alu_in1_d    = gnt_id_c ? req_in1[15:8]    : req_in1[7:0];
                    alu_in2_d    = gnt_id_c ? req_in2[15:8]    : req_in2[7:0];
                    alu_op_d     = gnt_id_c ? req_opcode[11:6] : req_opcode[5:0];
                    last_grant_d = gnt_id_c;
                    rid_d        = gnt_id_c;
                    cnt_d        = CNT_W'(ALU_LAT);
                end
            end
            S_WAIT: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (wait_done_c) begin
                    rsp_valid_d  = 1'b1;
                    rsp_id_d     = rid_q;
                    rsp_result_d = alu_result;
                    rsp_ovf_d    = alu_overflow;
                end
            end
            S_RESP: begin
                if (rsp_ready) rsp_valid_d = 1'b0;
            end
            default: ;
        endcase
    end

    // Datapath registers; reset drops any in-flight op without a response.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q        <= '0;
            last_grant_q <= 1'b1;
            rid_q        <= 1'b0;
            alu_in1_q    <= '0;
            alu_in2_q    <= '0;
            alu_op_q     <= IDLE_OP;
            rsp_valid_q  <= 1'b0;
            rsp_id_q     <= 1'b0;
            rsp_result_q <= '0;
            rsp_ovf_q    <= 1'b0;
        end else begin
            cnt_q        <= cnt_d;
            last_grant_q <= last_grant_d;
            rid_q        <= rid_d;
            alu_in1_q    <= alu_in1_d;
            alu_in2_q    <= alu_in2_d;
            alu_op_q     <= alu_op_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_id_q     <= rsp_id_d;
            rsp_result_q <= rsp_result_d;
            rsp_ovf_q    <= rsp_ovf_d;
        end
    end

    assign alu_in1      = alu_in1_q;
    assign alu_in2      = alu_in2_q;
    assign alu_opcode   = alu_op_q;
    assign rsp_valid    = rsp_valid_q;
    assign rsp_id       = rsp_id_q;
    assign rsp_result   = rsp_result_q;
    assign rsp_overflow = rsp_ovf_q;
    assign busy         = (state_q != S_IDLE);

endmodule
